// File: rtl/can_crc_generator.sv
// Transmit-side CAN CRC-15 engine: accumulates the CRC over SOF..data bits at each bit tick,
// then presents the 15 CRC bits MSB-first during the CRC field.
//
// state  | meaning
// IDLE   | cleared, waiting for the first CRC-covered bit
// ACCUM  | stepping the CRC on every covered-field tick
// SEND   | CRC frozen, o_CRC_bit = crc[idx], idx walks 14..0
// DONE   | all 15 CRC bits issued, bus left recessive
module can_crc_generator #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [5:0]  i_frame_field,
  input  logic        i_Data,
  output logic        o_CRC_bit,
  output logic        o_CRC_valid,
  output logic        o_CRC_done,
  output logic        o_CRC_err,
  output logic [14:0] o_CRC_value
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [5:0]  FIELD_CRC   = 6'd8;
  localparam logic [5:0]  FIELD_CLEAR = 6'd19;
  localparam logic [14:0] CRC_POLY    = 15'h4599;

  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [14:0]      crc_q, crc_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       state_q, state_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tick;
  logic             covered;
  logic             crc_x;

  assign tick    = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign covered = (i_frame_field <= 6'd7);
  assign crc_x   = i_Data ^ crc_q[14];

  always_comb begin
    clk_cnt_d = tick ? '0 : clk_cnt_q + CNT_W'(1);
    crc_d     = crc_q;
    idx_d     = idx_q;
    state_d   = state_q;
    done_d    = done_q;
    err_d     = err_q;

    if (tick) begin
      if (i_frame_field == FIELD_CLEAR) begin
        state_d = ST_IDLE;
        crc_d   = '0;
        idx_d   = 4'd14;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end else if (covered) begin
        if (state_q == ST_IDLE || state_q == ST_ACCUM) begin
          state_d = ST_ACCUM;
          crc_d   = {crc_q[13:0], 1'b0} ^ (crc_x ? CRC_POLY : 15'h0000);
        end else begin
          err_d = 1'b1;
        end
      end else if (i_frame_field == FIELD_CRC) begin
        case (state_q)
          ST_IDLE: begin
            // CRC field without any covered bits: emit an all-zero CRC and flag it.
            state_d = ST_SEND;
            crc_d   = '0;
            idx_d   = 4'd14;
            err_d   = 1'b1;
          end
          ST_ACCUM: begin
            state_d = ST_SEND;
            idx_d   = 4'd14;
          end
          ST_SEND: begin
            if (idx_q == 4'd0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q - 4'd1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      clk_cnt_q <= '0;
      crc_q     <= '0;
      idx_q     <= 4'd14;
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      crc_q     <= crc_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_CRC_bit   = (state_q == ST_SEND) ? crc_q[idx_q] : 1'b1;
  assign o_CRC_valid = (state_q == ST_SEND);
  assign o_CRC_done  = done_q;
  assign o_CRC_err   = err_q;
  assign o_CRC_value = crc_q;

endmodule

// File: tb/tb_can_crc_generator.sv
// Bench for can_crc_generator: cycle-by-cycle compare against a bit-level reference model,
// directed frames with literal expectations, and randomized frames checked by CRC loopback.
module tb_can_crc_generator;

  localparam int CPB = 10;

  logic        clk;
  logic        rst;
  logic [5:0]  i_frame_field;
  logic        i_Data;
  logic        o_CRC_bit;
  logic        o_CRC_valid;
  logic        o_CRC_done;
  logic        o_CRC_err;
  logic [14:0] o_CRC_value;

  can_crc_generator #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_frame_field(i_frame_field),
    .i_Data       (i_Data),
    .o_CRC_bit    (o_CRC_bit),
    .o_CRC_valid  (o_CRC_valid),
    .o_CRC_done   (o_CRC_done),
    .o_CRC_err    (o_CRC_err),
    .o_CRC_value  (o_CRC_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed = 0;
  int valid_clks = 0;
  int tb_cnt = 0;
  bit cap_q[$];
  bit data_q[$];

  // Reference: mode 0 idle, 1 accumulating, 2 sending, 3 finished; m_sent = CRC bits already issued.
  int m_mode, m_crc, m_sent;
  bit m_done, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int crc_step(input int crc, input bit b);
    int x;
    x = b ^ ((crc >> 14) & 1);
    return ((crc << 1) ^ (x != 0 ? 'h4599 : 0)) & 'h7fff;
  endfunction

  function automatic int crc_of(input bit q[$]);
    int c = 0;
    foreach (q[i]) c = crc_step(c, q[i]);
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else tb_cnt <= (tb_cnt == CPB - 1) ? 0 : tb_cnt + 1;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_crc <= 0; m_sent <= 0; m_done <= 0; m_err <= 0;
    end else if (tb_cnt == CPB - 1) begin
      if (i_frame_field == 19) begin
        m_mode <= 0; m_crc <= 0; m_sent <= 0; m_done <= 0; m_err <= 0;
      end else if (i_frame_field <= 7) begin
        if (m_mode <= 1) begin
          m_mode <= 1;
          m_crc  <= crc_step(m_crc, i_Data);
        end else m_err <= 1;
      end else if (i_frame_field == 8) begin
        if (m_mode == 0) begin
          m_mode <= 2; m_crc <= 0; m_sent <= 0; m_err <= 1;
        end else if (m_mode == 1) begin
          m_mode <= 2; m_sent <= 0;
        end else if (m_mode == 2) begin
          if (m_sent == 14) begin m_mode <= 3; m_done <= 1; end
          else m_sent <= m_sent + 1;
        end else m_err <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("crc_bit",   o_CRC_bit,   (m_mode == 2) ? ((m_crc >> (14 - m_sent)) & 1) : 1);
      chk("crc_valid", o_CRC_valid, m_mode == 2);
      chk("crc_done",  o_CRC_done,  m_done);
      chk("crc_err",   o_CRC_err,   m_err);
      chk("crc_value", o_CRC_value, m_crc);
      if (o_CRC_valid) valid_clks++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    armed = 1;
  endtask

  // Present one field/data pair for a full bit period, ending 1 time unit after its tick.
  task automatic bit_period(input int f, input bit d);
    bit was;
    i_frame_field = 6'(f);
    i_Data = d;
    do begin
      was = (tb_cnt == CPB - 1);
      @(posedge clk);
    end while (!was);
    #1;
    if (o_CRC_valid) cap_q.push_back(o_CRC_bit);
    if (f <= 7) data_q.push_back(d);
  endtask

  task automatic send_crc();
    cap_q.delete();
    repeat (16) bit_period(8, 0);
  endtask

  initial begin
    logic [14:0] pat;
    bit lb[$];
    int len, ones, pos;
    rst = 1'b1;
    i_frame_field = 6'd19;
    i_Data = 1'b0;
    @(posedge clk);
    do_reset();
    #1;
    chk("reset_bit", o_CRC_bit, 1);
    chk("reset_value", o_CRC_value, 0);

    // single 1 bit -> CRC equals the polynomial
    bit_period(0, 1);
    send_crc();
    pat = 15'h4599;
    chk("t1_value", o_CRC_value, 15'h4599);
    chk("t1_done", o_CRC_done, 1);
    chk("t1_nbits", cap_q.size(), 15);
    for (int i = 0; i < 15 && i < cap_q.size(); i++) chk("t1_bit", cap_q[i], pat[14 - i]);

    // overlong CRC field, then clear
    repeat (3) bit_period(8, 0);
    chk("t4_bit", o_CRC_bit, 1);
    chk("t4_err", o_CRC_err, 1);
    bit_period(19, 0);
    chk("t4_err_clr", o_CRC_err, 0);
    chk("t4_value_clr", o_CRC_value, 0);
    chk("t4_valid_clr", o_CRC_valid, 0);

    // two 1 bits
    do_reset();
    valid_clks = 0;
    bit_period(0, 1);
    bit_period(0, 1);
    send_crc();
    chk("t2_value", o_CRC_value, 15'h0B32);
    chk("t2_first", cap_q.size() > 0 ? cap_q[0] : 1'b1, 0);
    chk("t2_valid_clks", valid_clks, 15 * CPB);

    // 20 zero bits across fields 0..7
    do_reset();
    for (int i = 0; i < 20; i++) bit_period(i % 8, 0);
    send_crc();
    ones = 0;
    foreach (cap_q[i]) ones += cap_q[i];
    chk("t3_value", o_CRC_value, 0);
    chk("t3_err", o_CRC_err, 0);
    chk("t3_ones", ones, 0);
    chk("t3_nbits", cap_q.size(), 15);

    // reset in the middle of the CRC field
    do_reset();
    bit_period(0, 1);
    repeat (6) bit_period(8, 0);
    do_reset();
    chk("t5_bit", o_CRC_bit, 1);
    chk("t5_valid", o_CRC_valid, 0);
    chk("t5_done", o_CRC_done, 0);
    chk("t5_err", o_CRC_err, 0);
    chk("t5_value", o_CRC_value, 0);
    bit_period(0, 1);
    send_crc();
    chk("t5_refill", o_CRC_value, 15'h4599);

    // CRC field straight from idle
    do_reset();
    bit_period(8, 0);
    chk("idle8_err", o_CRC_err, 1);
    chk("idle8_valid", o_CRC_valid, 1);
    chk("idle8_bit", o_CRC_bit, 0);
    bit_period(19, 0);

    // randomized frames with loopback check
    for (int fr = 0; fr < 30; fr++) begin
      bit_period(19, 0);
      data_q.delete();
      len = $urandom_range(64, 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(7, 0) == 0) bit_period($urandom_range(18, 9), $urandom_range(1, 0));
        bit_period($urandom_range(7, 0), $urandom_range(1, 0));
      end
      send_crc();
      chk("rnd_nbits", cap_q.size(), 15);
      chk("rnd_err", o_CRC_err, 0);
      lb = data_q;
      foreach (cap_q[i]) lb.push_back(cap_q[i]);
      chk("loop_clean", crc_of(lb), 0);
      pos = data_q.size() + $urandom_range(14, 0);
      if (pos < lb.size()) lb[pos] = ~lb[pos];
      chk("loop_flip", crc_of(lb) != 0, 1);
    end

    armed = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
